// File: rtl/vmm_pkg.sv
// Shared definitions for the vector-matrix row accumulator: widths, FSM encoding
// and the saturating adder used to fold multiplier products into a row sum.
package vmm_pkg;

    localparam int N_TERMS_DEF = 16;
    localparam int PROD_W_DEF  = 32;
    localparam int ACC_W_DEF   = 40;
    localparam int SAT_W       = 64;  // widest accumulator sat_add supports

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    // Unsigned add clamped to 2^w-1; ovf reports that the clamp engaged.
    function automatic logic [SAT_W-1:0] sat_add(
        input  logic [SAT_W-1:0] a,
        input  logic [SAT_W-1:0] b,
        input  int unsigned      w,
        output logic             ovf
    );
        logic [SAT_W:0] sum;
        logic [SAT_W:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = ((SAT_W+1)'(1) << w) - (SAT_W+1)'(1);
        ovf = (sum > lim);
        return ovf ? lim[SAT_W-1:0] : sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/vmm_prod_skid.sv
// One-entry holding slot for a product that arrives while the finished row
// result is still waiting for its consumer; records a sticky loss flag.
module vmm_prod_skid #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic [W-1:0] dout,
    output logic         drop
);

    logic         full_reg;
    logic [W-1:0] data_reg;
    logic         drop_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_reg <= 1'b0;
            data_reg <= '0;
            drop_reg <= 1'b0;
        end else begin
            // A push onto an occupied slot loses the incoming product.
            if (push && full_reg)
                drop_reg <= 1'b1;
            if (clr || pop)
                full_reg <= 1'b0;
            else if (push)
                full_reg <= 1'b1;
            if (push && !full_reg && !clr)
                data_reg <= din;
        end
    end

    assign full = full_reg;
    assign dout = data_reg;
    assign drop = drop_reg;

endmodule

// File: rtl/vmm_row_accumulator.sv
// Sums N_TERMS multiplier products (captured on rising mul_done) into a
// saturated row result presented on a valid/ready output.
module vmm_row_accumulator
    import vmm_pkg::*;
#(
    parameter int N_TERMS = N_TERMS_DEF,
    parameter int PROD_W  = PROD_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    localparam int CNT_W  = $clog2(N_TERMS) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              row_start,
    input  logic              mul_done,
    input  logic [PROD_W-1:0] mul_product,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic [CNT_W-1:0]  term_cnt,
    output logic              busy,
    output logic              drop_err
);

    state_t             state_reg, state_next;
    logic [ACC_W-1:0]   acc_reg, acc_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               ovf_reg, ovf_next;
    logic               valid_reg, valid_next;
    logic [ACC_W-1:0]   sum_reg, sum_next;
    logic               done_q_reg;

    logic               cap, hs, do_add, add_ovf;
    logic [PROD_W-1:0]  add_val;
    logic [ACC_W-1:0]   add_sum;
    logic [CNT_W-1:0]   cnt_inc;
    logic               skid_clr, skid_push, skid_pop, pend_full;
    logic [PROD_W-1:0]  pend_data;

    vmm_prod_skid #(.W(PROD_W)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (skid_clr),
        .push  (skid_push),
        .pop   (skid_pop),
        .din   (mul_product),
        .full  (pend_full),
        .dout  (pend_data),
        .drop  (drop_err)
    );

    assign cap = mul_done & ~done_q_reg;
    assign hs  = valid_reg & out_ready;

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        ovf_next   = ovf_reg;
        valid_next = valid_reg;
        sum_next   = sum_reg;
        skid_clr   = 1'b0;
        skid_push  = 1'b0;
        skid_pop   = 1'b0;
        do_add     = 1'b0;
        add_val    = mul_product;

        if (row_start) begin
            state_next = ST_ACCUM;
            acc_next   = '0;
            cnt_next   = '0;
            ovf_next   = 1'b0;
            valid_next = 1'b0;
            skid_clr   = 1'b1;
            do_add     = cap;
        end else begin
            case (state_reg)
                ST_ACCUM: do_add = cap;
                ST_OUT: begin
                    if (hs) begin
                        state_next = ST_ACCUM;
                        acc_next   = '0;
                        cnt_next   = '0;
                        ovf_next   = 1'b0;
                        valid_next = 1'b0;
                        // A parked product opens the next row; a fresh one
                        // arriving alongside it has nowhere to go.
                        if (pend_full) begin
                            skid_pop  = 1'b1;
                            do_add    = 1'b1;
                            add_val   = pend_data;
                            skid_push = cap;
                        end else begin
                            do_add = cap;
                        end
                    end else begin
                        skid_push = cap;
                    end
                end
                default: ;
            endcase
        end

        add_sum = ACC_W'(sat_add(SAT_W'(acc_next), SAT_W'(add_val), ACC_W, add_ovf));
        cnt_inc = cnt_next + CNT_W'(1);

        if (do_add) begin
            acc_next = add_sum;
            cnt_next = cnt_inc;
            ovf_next = ovf_next | add_ovf;
            if (cnt_inc == CNT_W'(N_TERMS)) begin
                sum_next   = add_sum;
                valid_next = 1'b1;
                state_next = ST_OUT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            ovf_reg    <= 1'b0;
            valid_reg  <= 1'b0;
            sum_reg    <= '0;
            done_q_reg <= 1'b1;  // a done level already high at release is not a new product
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            cnt_reg    <= cnt_next;
            ovf_reg    <= ovf_next;
            valid_reg  <= valid_next;
            sum_reg    <= sum_next;
            done_q_reg <= mul_done;
        end
    end

    assign out_valid = valid_reg;
    assign out_sum   = sum_reg;
    assign out_ovf   = ovf_reg;
    assign term_cnt  = cnt_reg;
    assign busy      = (state_reg == ST_ACCUM) || (state_reg == ST_OUT);

endmodule
